// File: rtl/source_frame_sync.sv
// Frame synchroniser: hunts for a two-byte sync word, forwards a fixed-length payload,
// checks a modulo-256 trailer checksum and pads timed-out frames to full length.
module source_frame_sync #(
   parameter logic [15:0] SYNC_WORD   = 16'hEB90,
   parameter int          FRAME_BYTES = 944,
   parameter int          TIMEOUT     = 1000
) (
   input  logic        sys_clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  data,
   output logic        data_valid,
   output logic        frame_done,
   output logic        frame_err,
   output logic [15:0] frame_cnt,
   output logic [15:0] err_cnt,
   output logic        busy,
   output logic [2:0]  dbg_state
);

   // Handshake: rx_valid qualifies exactly one rx_data byte per cycle with no
   // backpressure; data_valid likewise qualifies one data byte per cycle, and
   // the downstream packer must accept every qualified byte.

   localparam int              IW       = $clog2(TIMEOUT + 1);
   localparam logic [9:0]      LAST_IDX = 10'(FRAME_BYTES - 1);
   localparam logic [IW-1:0]   IDLE_MAX = IW'(TIMEOUT);
   localparam logic [7:0]      SYNC_HI  = SYNC_WORD[15:8];
   localparam logic [7:0]      SYNC_LO  = SYNC_WORD[7:0];

   typedef enum logic [2:0] {
      S_HUNT    = 3'd0,
      S_SYNC2   = 3'd1,
      S_PAYLOAD = 3'd2,
      S_CHECK   = 3'd3,
      S_PAD     = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [7:0]      r_data;
   logic [7:0]      w_data_nxt;
   logic            r_dv;
   logic            w_dv_nxt;
   logic            r_done;
   logic            w_done_nxt;
   logic            r_err;
   logic            w_err_nxt;
   logic [9:0]      r_cnt;
   logic [9:0]      w_cnt_nxt;
   logic [7:0]      r_sum;
   logic [7:0]      w_sum_nxt;
   logic [IW-1:0]   r_idle;
   logic [IW-1:0]   w_idle_nxt;
   logic [15:0]     r_frame_cnt;
   logic [15:0]     r_err_cnt;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_HUNT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_data_nxt  = r_data;
      w_dv_nxt    = 1'b0;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      w_cnt_nxt   = r_cnt;
      w_sum_nxt   = r_sum;
      case (r_state)
         S_HUNT: begin
            if (rx_valid && rx_data == SYNC_HI) begin
               w_state_nxt = S_SYNC2;
            end
         end
         S_SYNC2: begin
            if (rx_valid) begin
               if (rx_data == SYNC_LO) begin
                  w_state_nxt = S_PAYLOAD;
                  w_cnt_nxt   = '0;
                  w_sum_nxt   = '0;
               end else if (rx_data != SYNC_HI) begin
                  w_state_nxt = S_HUNT;
               end
            end
         end
         S_PAYLOAD: begin
            // Timeout takes priority over a byte arriving on the same cycle.
            if (r_idle == IDLE_MAX) begin
               w_state_nxt = S_PAD;
            end else if (rx_valid) begin
               w_dv_nxt   = 1'b1;
               w_data_nxt = rx_data;
               w_sum_nxt  = r_sum + rx_data;
               w_cnt_nxt  = r_cnt + 10'd1;
               if (r_cnt == LAST_IDX) begin
                  w_state_nxt = S_CHECK;
               end
            end
         end
         S_CHECK: begin
            if (r_idle == IDLE_MAX) begin
               w_done_nxt  = 1'b1;
               w_err_nxt   = 1'b1;
               w_state_nxt = S_HUNT;
            end else if (rx_valid) begin
               w_done_nxt  = 1'b1;
               w_err_nxt   = (rx_data != r_sum);
               w_state_nxt = S_HUNT;
            end
         end
         S_PAD: begin
            // Zero-fill keeps the packer aligned to whole frames; rx is ignored.
            w_dv_nxt   = 1'b1;
            w_data_nxt = 8'h00;
            w_cnt_nxt  = r_cnt + 10'd1;
            if (r_cnt == LAST_IDX) begin
               w_done_nxt  = 1'b1;
               w_err_nxt   = 1'b1;
               w_state_nxt = S_HUNT;
            end
         end
         default: begin
            w_state_nxt = S_HUNT;
         end
      endcase
   end

   always_comb begin
      w_idle_nxt = '0;
      if (!rx_valid && (w_state_nxt == r_state) &&
          (r_state == S_PAYLOAD || r_state == S_CHECK)) begin
         w_idle_nxt = r_idle + 1'b1;
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data      <= 8'h00;
         r_dv        <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_cnt       <= '0;
         r_sum       <= '0;
         r_idle      <= '0;
         r_frame_cnt <= '0;
         r_err_cnt   <= '0;
      end else begin
         r_data <= w_data_nxt;
         r_dv   <= w_dv_nxt;
         r_done <= w_done_nxt;
         r_err  <= w_err_nxt;
         r_cnt  <= w_cnt_nxt;
         r_sum  <= w_sum_nxt;
         r_idle <= w_idle_nxt;
         if (w_done_nxt) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
         if (w_err_nxt && r_err_cnt != 16'hFFFF) begin
            r_err_cnt <= r_err_cnt + 16'd1;
         end
      end
   end

   assign data       = r_data;
   assign data_valid = r_dv;
   assign frame_done = r_done;
   assign frame_err  = r_err;
   assign frame_cnt  = r_frame_cnt;
   assign err_cnt    = r_err_cnt;
   assign busy       = (r_state != S_HUNT);
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_source_frame_sync.sv
// Bench for source_frame_sync: table-driven frames, corner sequences and random
// frames scored against payload/error queues built by the frame generator.
module tb_source_frame_sync;

  localparam int         FB      = 944;
  localparam int         TMO     = 1000;
  localparam logic [2:0] ST_HUNT = 3'd0;

  logic        sys_clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  data;
  logic        data_valid;
  logic        frame_done;
  logic        frame_err;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;
  logic        busy;
  logic [2:0]  dbg_state;

  source_frame_sync #(
    .SYNC_WORD  (16'hEB90),
    .FRAME_BYTES(FB),
    .TIMEOUT    (TMO)
  ) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .data      (data),
    .data_valid(data_valid),
    .frame_done(frame_done),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;
  int dv_count   = 0;
  int done_count = 0;
  int exp_fcnt   = 0;
  int exp_ecnt   = 0;

  logic [7:0] exp_q[$];
  bit         err_q[$];

  typedef struct {
    int         pre;
    logic [7:0] tr_xor;
    bit         exp_err;
    int         exp_bytes;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // scoreboard: every qualified output byte and every frame_done is consumed here
  always @(negedge sys_clk) begin
    if (rst_n) begin
      if (data_valid) begin
        dv_count++;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_byte: got=%0h want=none", data);
        end else begin
          check("payload", 32'(data), 32'(exp_q.pop_front()));
        end
      end
      if (frame_done) begin
        done_count++;
        if (err_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got=1 want=0");
        end else begin
          check("frame_err", 32'(frame_err), 32'(err_q.pop_front()));
        end
      end else if (frame_err) begin
        total++; bad++;
        $display("FAIL err_without_done: got=1 want=0");
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sys_clk); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge sys_clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_pre(input int pre);
    case (pre)
      1: begin send_byte(8'hEB); send_byte(8'hEB); send_byte(8'h90); end
      2: begin
        send_byte(8'h12); send_byte(8'hEB); send_byte(8'h34);
        send_byte(8'hEB); send_byte(8'h90);
      end
      default: begin send_byte(8'hEB); send_byte(8'h90); end
    endcase
  endtask

  task automatic send_frame(input int pre, input logic [7:0] tr_xor, input bit exp_err,
                            input bit rnd, input int max_idle);
    logic [7:0] pl[FB];
    logic [7:0] sum;
    sum = 8'h00;
    for (int i = 0; i < FB; i++) begin
      pl[i] = rnd ? 8'($urandom_range(0, 255)) : 8'(i % 256);
      sum   = sum + pl[i];
      exp_q.push_back(pl[i]);
    end
    send_pre(pre);
    check("sync_not_forwarded", 32'(data_valid), 32'd0);
    check("busy_in_frame", 32'(busy), 32'd1);
    for (int i = 0; i < FB; i++) begin
      send_byte(pl[i]);
      if (i == 0) begin
        check("latency_valid", 32'(data_valid), 32'd1);
        check("latency_data", 32'(data), 32'(pl[0]));
      end
      if (max_idle > 0) idle($urandom_range(0, max_idle));
    end
    err_q.push_back(exp_err);
    send_byte(sum ^ tr_xor);
    check("done_latency", 32'(frame_done), 32'd1);
    check("err_latency", 32'(frame_err), 32'(exp_err));
  endtask

  task automatic wait_frames(input int target);
    for (int i = 0; i < 3000 && done_count < target; i++) begin
      @(posedge sys_clk); #2;
    end
    check("frame_done_seen", 32'(done_count), 32'(target));
  endtask

  task automatic check_counters();
    check("frame_cnt", 32'(frame_cnt), 32'(exp_fcnt));
    check("err_cnt", 32'(err_cnt), 32'(exp_ecnt));
    check("busy_after", 32'(busy), 32'd0);
    check("state_hunt", 32'(dbg_state), 32'(ST_HUNT));
  endtask

  task automatic run_frame(input int pre, input logic [7:0] tr_xor, input bit exp_err,
                           input bit rnd, input int max_idle, input int exp_bytes);
    int dv0;
    int d0;
    dv0 = dv_count;
    d0  = done_count;
    send_frame(pre, tr_xor, exp_err, rnd, max_idle);
    wait_frames(d0 + 1);
    exp_fcnt++;
    if (exp_err) exp_ecnt++;
    check("frame_bytes", 32'(dv_count - dv0), 32'(exp_bytes));
    check_counters();
  endtask

  initial begin
    int dv0;
    int d0;
    logic [7:0] b;

    vecs[0] = '{pre: 0, tr_xor: 8'h00, exp_err: 1'b0, exp_bytes: FB};
    vecs[1] = '{pre: 0, tr_xor: 8'h01, exp_err: 1'b1, exp_bytes: FB};
    vecs[2] = '{pre: 1, tr_xor: 8'h00, exp_err: 1'b0, exp_bytes: FB};
    vecs[3] = '{pre: 2, tr_xor: 8'h00, exp_err: 1'b0, exp_bytes: FB};
    vecs[4] = '{pre: 2, tr_xor: 8'h80, exp_err: 1'b1, exp_bytes: FB};

    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_data", 32'(data), 32'd0);
    check("rst_dv", 32'(data_valid), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check_counters();
    rst_n = 1'b1;
    idle(2);

    // table-driven frames
    for (int v = 0; v < 5; v++) begin
      run_frame(vecs[v].pre, vecs[v].tr_xor, vecs[v].exp_err, 1'b0, 0, vecs[v].exp_bytes);
    end

    // timeout mid-payload: 500 bytes then silence, padded out with zeros
    dv0 = dv_count;
    d0  = done_count;
    for (int i = 0; i < 500; i++) exp_q.push_back(8'(i % 256));
    for (int i = 500; i < FB; i++) exp_q.push_back(8'h00);
    err_q.push_back(1'b1);
    send_pre(0);
    for (int i = 0; i < 500; i++) send_byte(8'(i % 256));
    idle(900);
    check("no_early_pad", 32'(dv_count - dv0), 32'd500);
    check("busy_while_idle", 32'(busy), 32'd1);
    idle(110);
    send_byte(8'hEB); send_byte(8'h90); send_byte(8'h55);
    wait_frames(d0 + 1);
    exp_fcnt++;
    exp_ecnt++;
    check("pad_total_bytes", 32'(dv_count - dv0), 32'(FB));
    check_counters();

    // reset at payload byte 300
    for (int i = 0; i < 300; i++) exp_q.push_back(8'(i % 256));
    d0 = done_count;
    send_pre(0);
    for (int i = 0; i < 300; i++) send_byte(8'(i % 256));
    rst_n = 1'b0;
    #1;
    check("midrst_data", 32'(data), 32'd0);
    check("midrst_dv", 32'(data_valid), 32'd0);
    check("midrst_done", 32'(frame_done), 32'd0);
    exp_q.delete();
    exp_fcnt = 0;
    exp_ecnt = 0;
    check_counters();
    repeat (2) @(posedge sys_clk);
    #1;
    rst_n = 1'b1;
    send_byte(8'h90); send_byte(8'h00); send_byte(8'h55);
    idle(5);
    check("no_done_after_rst", 32'(done_count), 32'(d0));
    check_counters();
    run_frame(0, 8'h00, 1'b0, 1'b0, 0, FB);

    // three back-to-back frames, zero gap
    dv0 = dv_count;
    d0  = done_count;
    for (int k = 0; k < 3; k++) send_frame(0, 8'h00, 1'b0, 1'b1, 0);
    wait_frames(d0 + 3);
    exp_fcnt += 3;
    check("b2b_bytes", 32'(dv_count - dv0), 32'(3 * FB));
    check_counters();

    // random frames with junk, gaps and corrupted trailers
    for (int k = 0; k < 6; k++) begin
      bit         bad_sum;
      logic [7:0] mask;
      repeat ($urandom_range(0, 4)) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hEB) b = 8'h00;
        send_byte(b);
      end
      idle($urandom_range(0, 20));
      bad_sum = 1'($urandom_range(0, 1));
      mask    = bad_sum ? 8'($urandom_range(1, 255)) : 8'h00;
      run_frame($urandom_range(0, 2), mask, bad_sum, 1'b1, 2 * $urandom_range(0, 1), FB);
    end

    idle(5);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("err_q_drained", 32'(err_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/source_frame_sync.md
SOURCE_FRAME_SYNC -- requirements
Module: source_frame_sync

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 16'hEB90, meaning the two-byte frame header, high byte first.
REQ-002 SHALL have parameter FRAME_BYTES, default 944, meaning payload bytes per frame (59 x 16-byte words for the downstream packer).
REQ-003 SHALL have parameter TIMEOUT, default 1000, meaning idle cycles allowed without rx_valid inside a frame.
REQ-004 SHALL have port sys_clk  in  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rx_data  in  8  raw received byte.
REQ-007 SHALL have port rx_valid  in  1  rx_data qualifier, one byte per asserted cycle.
REQ-008 SHALL have port data  out  8  payload byte to the source-RAM packer.
REQ-009 SHALL have port data_valid  out  1  data qualifier; asserted exactly FRAME_BYTES cycles per accepted frame.
REQ-010 SHALL have port frame_done  out  1  one-cycle pulse at end of every frame.
REQ-011 SHALL have port frame_err  out  1  one-cycle pulse, coincident with frame_done, on checksum mismatch or timeout.
REQ-012 SHALL have port frame_cnt  out  16  completed frames, wraps at 16'hFFFF.
REQ-013 SHALL have port err_cnt  out  16  errored frames, saturates at 16'hFFFF.
REQ-014 SHALL have port busy  out  1  high in any state other than HUNT.

Function
REQ-015 SHALL implement FSM states HUNT, SYNC2, PAYLOAD, CHECK, PAD; reset state HUNT.
REQ-016 HUNT: rx_valid with rx_data==SYNC_WORD[15:8] -> SYNC2; otherwise stay.
REQ-017 SYNC2: on rx_valid, byte==SYNC_WORD[7:0] -> PAYLOAD; byte==SYNC_WORD[15:8] -> stay SYNC2; other byte -> HUNT; no timeout in SYNC2.
REQ-018 PAYLOAD: each rx_valid byte SHALL appear on data with data_valid exactly 1 cycle later (registered outputs).
REQ-019 PAYLOAD: 10-bit byte counter cleared on SYNC2->PAYLOAD; after byte FRAME_BYTES-1 (count 943) accepted -> CHECK.
REQ-020 Checksum: 8-bit modulo-256 sum of all payload bytes, cleared on entry to PAYLOAD; carries discarded.
REQ-021 CHECK: next rx_valid byte is the trailer and is not forwarded; frame_done pulses 1 cycle later; frame_err also pulses if trailer != sum; -> HUNT.
REQ-022 Idle counter: cleared on every rx_valid and on state change; increments each cycle without rx_valid in PAYLOAD or CHECK.
REQ-023 Timeout in PAYLOAD (idle == TIMEOUT): -> PAD; rx ignored thereafter until HUNT.
REQ-024 PAD: emit data=8'h00 with data_valid every cycle until total emitted == FRAME_BYTES, then frame_done+frame_err pulse, -> HUNT; downstream alignment preserved.
REQ-025 Timeout in CHECK: frame_done+frame_err pulse, -> HUNT.
REQ-026 frame_cnt increments on every frame_done; err_cnt increments on every frame_err unless already 16'hFFFF.
REQ-027 Sync bytes inside payload SHALL be treated as data (no resync mid-frame).
REQ-028 Bytes arriving in HUNT after frame_done SHALL be searched normally; back-to-back frames with zero gap SHALL be accepted.

Reset
REQ-029 On rst_n low, asynchronously: state HUNT, data 8'h00, data_valid 0, frame_done 0, frame_err 0, frame_cnt 0, err_cnt 0, busy 0, all internal counters and checksum 0.
REQ-030 Reset mid-frame SHALL abandon the frame with no frame_done; after release, next frame requires a fresh sync word.

Verification
REQ-031 Good frame: EB 90, bytes 0..943 (value i mod 256), trailer = correct sum -> 944 data_valid cycles, data matches, frame_done=1, frame_err=0, frame_cnt=1.
REQ-032 Bad checksum: same frame, trailer = correct sum ^ 8'h01 -> 944 bytes forwarded, frame_done=1 and frame_err=1, err_cnt=1.
REQ-033 False sync: EB EB 90 then frame -> locks on second EB; 12 EB 34 EB 90 then frame -> locks only at final EB 90.
REQ-034 Timeout: EB 90, 500 bytes, rx_valid low 1000 cycles -> PAD emits 444 zero bytes (total 944), frame_done+frame_err, busy falls, state HUNT.
REQ-035 Reset at payload byte 300: assert rst_n low 2 cycles -> all outputs zero, no frame_done; next complete good frame -> frame_cnt=1.
REQ-036 Back-to-back: three good frames with no idle gaps -> 2832 data_valid cycles, three frame_done pulses, frame_cnt=3, err_cnt=0.
